// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command executor.
//  - command codes carried in word[33:32]
//  - response tags carried in o_rsp_word[33:32]
//  - error payload codes for the error response
//  - executor state encoding
package uart_cmd_pkg;
   localparam int WORD_W = 34;

   localparam logic [1:0] CMD_R = 2'b00;
   localparam logic [1:0] CMD_W = 2'b01;
   localparam logic [1:0] CMD_A = 2'b10;
   localparam logic [1:0] CMD_S = 2'b11;

   localparam logic [1:0] RSP_RD   = 2'b00;
   localparam logic [1:0] RSP_WR   = 2'b01;
   localparam logic [1:0] RSP_ADDR = 2'b10;
   localparam logic [1:0] RSP_ERR  = 2'b11;

   localparam logic [31:0] ERR_BUS     = 32'h1;
   localparam logic [31:0] ERR_TIMEOUT = 32'h2;
   localparam logic [31:0] ERR_OVF     = 32'h3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_BUS,
      ST_RSP
   } state_t;
endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous show-ahead FIFO for command words.
// Ports:
//  i_clk, rst     clock, async active-low reset
//  push, wdata    write request; ignored while full
//  pop            read request; ignored while empty
//  rdata          word at the head (valid while !empty)
//  full, empty    occupancy flags, based on the current count only
module uart_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 34
) (
   input  logic             i_clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic [AW:0]      cnt;
   logic             do_push, do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   // A pop in the same cycle does not free a slot for the push.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rp];

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wp] <= wdata;
   end

   always_ff @(posedge i_clk or negedge rst) begin
      if (!rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/uart_cmd_executor.sv
// Executes decoded UART command words on a single-master req/ack bus.
// Ports:
//  i_clk, rst                clock, async active-low reset
//  i_stb, i_word             command word strobe {cmd[1:0], data[31:0]}
//  o_bus_cyc/we/addr/wdata   bus request, stable while o_bus_cyc is high
//  i_bus_ack/err/rdata       bus completion
//  o_rsp_stb, o_rsp_word     response strobe and registered response word
//  i_rsp_busy                holds off o_rsp_stb
//  o_overflow                sticky flag: a command was dropped on a full FIFO
module uart_cmd_executor import uart_cmd_pkg::*; #(
   parameter int FIFO_DEPTH      = 4,
   parameter int TIMEOUT         = 255,
   parameter int ADDR_STEP       = 4,
   parameter int AUTOINC_DEFAULT = 1
) (
   input  logic              i_clk,
   input  logic              rst,
   input  logic              i_stb,
   input  logic [WORD_W-1:0] i_word,
   output logic              o_bus_cyc,
   output logic              o_bus_we,
   output logic [31:0]       o_bus_addr,
   output logic [31:0]       o_bus_wdata,
   input  logic              i_bus_ack,
   input  logic              i_bus_err,
   input  logic [31:0]       i_bus_rdata,
   output logic              o_rsp_stb,
   output logic [WORD_W-1:0] o_rsp_word,
   input  logic              i_rsp_busy,
   output logic              o_overflow
);
   localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [WORD_W-1:0] fifo_rdata, cmd_word, rsp_nxt;
   logic              fifo_full, fifo_empty, fifo_pop;
   logic [31:0]       addr, addr_nxt, tcnt;
   logic              autoinc, rsp_ovf, rsp_ovf_nxt;
   logic              ld_word, addr_ld, ainc_ld, rsp_ld, ovf_clr, tcnt_clr, to_hit;
   logic [1:0]        cmd;

   uart_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
      .i_clk (i_clk),
      .rst   (rst),
      .push  (i_stb),
      .wdata (i_word),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign cmd         = cmd_word[33:32];
   assign o_bus_cyc   = (state == ST_BUS);
   assign o_bus_we    = (cmd == CMD_W);
   assign o_bus_addr  = addr;
   assign o_bus_wdata = cmd_word[31:0];
   assign o_rsp_stb   = (state == ST_RSP) && !i_rsp_busy;
   // tcnt counts completed cyc cycles; the TIMEOUT-th one without ack/err ends the transfer.
   assign to_hit      = (TIMEOUT != 0) && (tcnt == TO_LAST);

   always_ff @(posedge i_clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      fifo_pop    = 1'b0;
      ld_word     = 1'b0;
      addr_ld     = 1'b0;
      addr_nxt    = addr;
      ainc_ld     = 1'b0;
      rsp_ld      = 1'b0;
      rsp_nxt     = o_rsp_word;
      rsp_ovf_nxt = 1'b0;
      ovf_clr     = 1'b0;
      tcnt_clr    = 1'b0;
      case (state)
         ST_IDLE: begin
            // A pending overflow is reported before any further command runs.
            if (o_overflow) begin
               rsp_ld      = 1'b1;
               rsp_nxt     = {RSP_ERR, ERR_OVF};
               rsp_ovf_nxt = 1'b1;
               state_nxt   = ST_RSP;
            end else if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               ld_word   = 1'b1;
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (cmd)
               CMD_A: begin
                  addr_ld   = 1'b1;
                  addr_nxt  = cmd_word[31:0];
                  rsp_ld    = 1'b1;
                  rsp_nxt   = {RSP_ADDR, cmd_word[31:0]};
                  state_nxt = ST_RSP;
               end
               CMD_S: begin
                  ainc_ld   = 1'b1;
                  state_nxt = ST_IDLE;
               end
               default: begin
                  tcnt_clr  = 1'b1;
                  state_nxt = ST_BUS;
               end
            endcase
         end
         ST_BUS: begin
            if (i_bus_err) begin
               rsp_ld    = 1'b1;
               rsp_nxt   = {RSP_ERR, ERR_BUS};
               state_nxt = ST_RSP;
            end else if (i_bus_ack) begin
               rsp_ld    = 1'b1;
               rsp_nxt   = (cmd == CMD_W) ? {RSP_WR, addr} : {RSP_RD, i_bus_rdata};
               addr_ld   = autoinc;
               addr_nxt  = addr + 32'(ADDR_STEP);
               state_nxt = ST_RSP;
            end else if (to_hit) begin
               rsp_ld    = 1'b1;
               rsp_nxt   = {RSP_ERR, ERR_TIMEOUT};
               state_nxt = ST_RSP;
            end
         end
         ST_RSP: begin
            if (!i_rsp_busy) begin
               ovf_clr   = rsp_ovf;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge rst) begin
      if (!rst) begin
         addr       <= '0;
         autoinc    <= 1'(AUTOINC_DEFAULT);
         cmd_word   <= '0;
         o_rsp_word <= '0;
         rsp_ovf    <= 1'b0;
         tcnt       <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (ld_word) cmd_word <= fifo_rdata;
         if (addr_ld) addr     <= addr_nxt;
         if (ainc_ld) autoinc  <= cmd_word[0];
         if (rsp_ld) begin
            o_rsp_word <= rsp_nxt;
            rsp_ovf    <= rsp_ovf_nxt;
         end
         if (tcnt_clr)            tcnt <= '0;
         else if (state == ST_BUS) tcnt <= tcnt + 1'b1;
         // A rejected push in the clearing cycle keeps the flag set.
         if (i_stb && fifo_full) o_overflow <= 1'b1;
         else if (ovf_clr)       o_overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_cmd_executor.sv
module tb_uart_cmd_executor;
   logic        i_clk = 1'b0;
   logic        rst;
   logic        i_stb;
   logic [33:0] i_word;
   logic        o_bus_cyc, o_bus_we;
   logic [31:0] o_bus_addr, o_bus_wdata;
   logic        i_bus_ack, i_bus_err;
   logic [31:0] i_bus_rdata;
   logic        o_rsp_stb;
   logic [33:0] o_rsp_word;
   logic        i_rsp_busy;
   logic        o_overflow;

   int checks   = 0;
   int failures = 0;
   int rsp_cnt  = 0;
   logic [33:0] exp_q[$];

   always #5 i_clk = ~i_clk;

   uart_cmd_executor #(
      .FIFO_DEPTH(4), .TIMEOUT(16), .ADDR_STEP(4), .AUTOINC_DEFAULT(1)
   ) dut (
      .i_clk(i_clk), .rst(rst), .i_stb(i_stb), .i_word(i_word),
      .o_bus_cyc(o_bus_cyc), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
      .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack), .i_bus_err(i_bus_err),
      .i_bus_rdata(i_bus_rdata), .o_rsp_stb(o_rsp_stb), .o_rsp_word(o_rsp_word),
      .i_rsp_busy(i_rsp_busy), .o_overflow(o_overflow)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Scoreboard: every response strobe must match the oldest expected word.
   always @(negedge i_clk) begin
      if (rst && o_rsp_stb) begin
         if (exp_q.size() == 0) chk("rsp_spurious", 64'(o_rsp_stb), 64'd0);
         else chk("rsp_word", 64'(o_rsp_word), 64'(exp_q.pop_front()));
         rsp_cnt++;
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic push(input logic [1:0] c, input logic [31:0] d);
      i_stb  = 1'b1;
      i_word = {c, d};
      step();
      i_stb  = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      int t = 0;
      while (rsp_cnt < target && t < 300) begin
         step();
         t++;
      end
      chk("rsp_count", 64'(rsp_cnt), 64'(target));
   endtask

   // mode: 0 ack, 1 err, 2 no reply (timeout), 3 ack and err together
   task automatic bus_xfer(input int dly, input logic [31:0] rd, input int mode,
                           input logic we, input logic [31:0] addr, input logic [31:0] wd);
      int t = 0;
      while (!o_bus_cyc && t < 50) begin
         @(negedge i_clk);
         t++;
      end
      chk("cyc_start", 64'(o_bus_cyc), 64'd1);
      if (!o_bus_cyc) return;
      chk("bus_we", 64'(o_bus_we), 64'(we));
      chk("bus_addr", 64'(o_bus_addr), 64'(addr));
      if (we) chk("bus_wdata", 64'(o_bus_wdata), 64'(wd));
      if (mode == 2) begin
         t = 0;
         while (o_bus_cyc && t < 100) begin
            @(negedge i_clk);
            t++;
         end
         chk("timeout_len", 64'(t), 64'd16);
      end else begin
         repeat (dly) @(negedge i_clk);
         chk("cyc_hold", 64'(o_bus_cyc), 64'd1);
         i_bus_ack   = (mode == 0 || mode == 3);
         i_bus_err   = (mode == 1 || mode == 3);
         i_bus_rdata = rd;
         @(negedge i_clk);
         i_bus_ack   = 1'b0;
         i_bus_err   = 1'b0;
         i_bus_rdata = '0;
         chk("cyc_end", 64'(o_bus_cyc), 64'd0);
      end
   endtask

   initial begin
      rst = 1'b0; i_stb = 1'b0; i_word = '0;
      i_bus_ack = 1'b0; i_bus_err = 1'b0; i_bus_rdata = '0; i_rsp_busy = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_cyc", 64'(o_bus_cyc), 64'd0);
      chk("rst_we", 64'(o_bus_we), 64'd0);
      chk("rst_addr", 64'(o_bus_addr), 64'd0);
      chk("rst_wdata", 64'(o_bus_wdata), 64'd0);
      chk("rst_stb", 64'(o_rsp_stb), 64'd0);
      chk("rst_word", 64'(o_rsp_word), 64'd0);
      chk("rst_ovf", 64'(o_overflow), 64'd0);
      rst = 1'b1;
      step();

      // 1: address set with latency check, then a write
      exp_q.push_back({2'b10, 32'h10});
      push(2'b10, 32'h10);
      step();
      chk("lat_early", 64'(o_rsp_stb), 64'd0);
      step();
      chk("lat_n3", 64'(o_rsp_stb), 64'd1);
      wait_rsp(1);
      exp_q.push_back({2'b01, 32'h10});
      push(2'b01, 32'hDEADBEEF);
      bus_xfer(3, 32'h0, 0, 1'b1, 32'h10, 32'hDEADBEEF);
      wait_rsp(2);
      chk("addr_inc_w", 64'(o_bus_addr), 64'h14);

      // 2: read
      exp_q.push_back({2'b00, 32'h12345678});
      push(2'b00, 32'h0);
      bus_xfer(1, 32'h12345678, 0, 1'b0, 32'h14, 32'h0);
      wait_rsp(3);
      chk("addr_inc_r", 64'(o_bus_addr), 64'h18);

      // 3: timeout, then err beating ack
      exp_q.push_back({2'b11, 32'h2});
      push(2'b00, 32'h0);
      bus_xfer(0, 32'h0, 2, 1'b0, 32'h18, 32'h0);
      wait_rsp(4);
      chk("addr_to", 64'(o_bus_addr), 64'h18);
      exp_q.push_back({2'b11, 32'h1});
      push(2'b01, 32'h55);
      bus_xfer(2, 32'h0, 3, 1'b1, 32'h18, 32'h55);
      wait_rsp(5);
      chk("addr_err", 64'(o_bus_addr), 64'h18);

      // 6: address wrap and autoincrement disable
      exp_q.push_back({2'b10, 32'hFFFFFFFC});
      push(2'b10, 32'hFFFFFFFC);
      wait_rsp(6);
      exp_q.push_back({2'b01, 32'hFFFFFFFC});
      push(2'b01, 32'h1);
      bus_xfer(0, 32'h0, 0, 1'b1, 32'hFFFFFFFC, 32'h1);
      wait_rsp(7);
      exp_q.push_back({2'b01, 32'h0});
      push(2'b01, 32'h2);
      bus_xfer(0, 32'h0, 0, 1'b1, 32'h0, 32'h2);
      wait_rsp(8);
      chk("addr_wrap", 64'(o_bus_addr), 64'h4);
      push(2'b11, 32'h0);
      exp_q.push_back({2'b01, 32'h4});
      push(2'b01, 32'h3);
      bus_xfer(0, 32'h0, 0, 1'b1, 32'h4, 32'h3);
      wait_rsp(9);
      chk("addr_noinc", 64'(o_bus_addr), 64'h4);
      push(2'b11, 32'h1);

      // 4: overflow while the response path is stalled
      i_rsp_busy = 1'b1;
      exp_q.push_back({2'b10, 32'h100});
      push(2'b10, 32'h100);
      repeat (4) step();
      for (int i = 0; i < 6; i++) begin
         i_stb  = 1'b1;
         i_word = {2'b10, 32'h200 + 32'(i)};
         step();
      end
      i_stb = 1'b0;
      chk("ovf_set", 64'(o_overflow), 64'd1);
      exp_q.push_back({2'b11, 32'h3});
      for (int i = 0; i < 4; i++) exp_q.push_back({2'b10, 32'h200 + 32'(i)});
      repeat (3) step();
      i_rsp_busy = 1'b0;
      wait_rsp(15);
      chk("ovf_clr", 64'(o_overflow), 64'd0);
      chk("addr_ovf", 64'(o_bus_addr), 64'h203);

      // 5: reset in the middle of a bus transfer, with a word still queued
      push(2'b00, 32'h0);
      push(2'b10, 32'h77);
      begin
         int t = 0;
         while (!o_bus_cyc && t < 50) begin
            @(negedge i_clk);
            t++;
         end
      end
      chk("rst_pre_cyc", 64'(o_bus_cyc), 64'd1);
      rst = 1'b0;
      #1;
      chk("rst_mid_cyc", 64'(o_bus_cyc), 64'd0);
      chk("rst_mid_addr", 64'(o_bus_addr), 64'd0);
      @(negedge i_clk);
      rst = 1'b1;
      repeat (10) step();
      chk("post_rst_cyc", 64'(o_bus_cyc), 64'd0);
      chk("post_rst_rsp", 64'(rsp_cnt), 64'd15);
      chk("q_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
